// File: rtl/vending_pkg.sv
// Shared types and helpers for the vending controller.
//   coin_t     : coin code as seen on the validator and hopper interfaces
//   state_t    : controller states
//   coin_value : coin code -> value in 50 ct units
package vending_pkg;

   typedef enum logic [1:0] {
      NONE = 2'b00,
      C50  = 2'b01,
      C100 = 2'b10,
      C200 = 2'b11
   } coin_t;

   typedef enum logic [1:0] {
      COLLECT  = 2'd0,
      DISPENSE = 2'd1,
      CHANGE   = 2'd2
   } state_t;

   function automatic logic [2:0] coin_value(input coin_t code);
      logic [2:0] v;
      case (code)
         C50:     v = 3'd1;
         C100:    v = 3'd2;
         C200:    v = 3'd4;
         default: v = 3'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/vending_change_sel.sv
// Picks the largest coin that does not exceed the given credit.
// Shared by the refund and change paths.
//   credit : remaining credit in 50 ct units
//   code   : coin code to present to the hopper (C50 when credit < 2, incl. 0)
//   value  : value of that coin in 50 ct units
module vending_change_sel
   import vending_pkg::*;
#(
   parameter int CREDIT_W = 4
) (
   input  logic [CREDIT_W-1:0] credit,
   output coin_t               code,
   output logic [CREDIT_W-1:0] value
);

   logic [31:0] credit_ext;

   always_comb begin
      credit_ext = 32'(credit);
      code       = C50;
      if (credit_ext >= 32'd4) begin
         code = C200;
      end else if (credit_ext >= 32'd2) begin
         code = C100;
      end
      value = CREDIT_W'(coin_value(code));
   end

endmodule

// File: rtl/vending_ctrl.sv
// Parametrised vending controller: accumulates coin credit, requests a
// dispense once credit covers PRICE, then pays change / refunds one coin at
// a time over the hopper handshake, and counts completed sales.
//   clk, rst      : clock, synchronous active-high reset
//   coin          : incoming coin code (00 none, 01 50ct, 10 1EUR, 11 2EUR)
//   cancel        : refund request
//   dispense_ack  : product released
//   change_ready  : hopper takes the presented coin
//   dispense      : dispense request, held until acknowledged
//   change_valid  : a coin is presented to the hopper
//   change_coin   : code of the presented coin
//   coin_reject   : pulse, previous cycle's coin was not credited
//   credit        : current credit in 50 ct units
//   sales         : completed sales, wraps
module vending_ctrl
   import vending_pkg::*;
#(
   parameter int PRICE      = 3,
   parameter int CREDIT_W   = 4,
   parameter int MAX_CREDIT = 15,
   parameter int SALES_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          coin,
   input  logic                cancel,
   input  logic                dispense_ack,
   input  logic                change_ready,
   output logic                dispense,
   output logic                change_valid,
   output logic [1:0]          change_coin,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   output logic [SALES_W-1:0]  sales
);

   if (!(PRICE >= 1 && PRICE <= MAX_CREDIT && MAX_CREDIT <= (2**CREDIT_W) - 1)) begin : g_param_check
      $error("vending_ctrl: illegal PRICE/MAX_CREDIT/CREDIT_W combination");
   end

   // Sum is one bit wider than credit so an overpay is detected, not wrapped.
   localparam int SUM_W = (CREDIT_W + 1 > 3) ? CREDIT_W + 1 : 3;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [SALES_W-1:0]  sales_q, sales_d;
   logic                reject_q, reject_d;

   coin_t               coin_in;
   logic                coin_present;
   logic [SUM_W-1:0]    coin_sum;
   coin_t               sel_code;
   logic [CREDIT_W-1:0] sel_value;
   logic [CREDIT_W-1:0] credit_left;

   assign coin_in      = coin_t'(coin);
   assign coin_present = (coin_in != NONE);
   assign coin_sum     = SUM_W'(credit_q) + SUM_W'(coin_value(coin_in));
   assign credit_left  = credit_q - sel_value;

   vending_change_sel #(
      .CREDIT_W (CREDIT_W)
   ) u_change_sel (
      .credit (credit_q),
      .code   (sel_code),
      .value  (sel_value)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= COLLECT;
         credit_q <= '0;
         sales_q  <= '0;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         sales_q  <= sales_d;
         reject_q <= reject_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      sales_d  = sales_q;
      reject_d = 1'b0;
      case (state_q)
         COLLECT: begin
            // Purchase commit outranks cancel; both reject a coin in flight.
            if (credit_q >= CREDIT_W'(PRICE)) begin
               state_d  = DISPENSE;
               credit_d = credit_q - CREDIT_W'(PRICE);
               reject_d = coin_present;
            end else if (cancel && credit_q != '0) begin
               state_d  = CHANGE;
               reject_d = coin_present;
            end else if (coin_present) begin
               if (coin_sum <= SUM_W'(MAX_CREDIT)) begin
                  credit_d = CREDIT_W'(coin_sum);
               end else begin
                  reject_d = 1'b1;
               end
            end
         end
         DISPENSE: begin
            reject_d = coin_present;
            if (dispense_ack) begin
               sales_d = sales_q + SALES_W'(1);
               state_d = (credit_q != '0) ? CHANGE : COLLECT;
            end
         end
         CHANGE: begin
            reject_d = coin_present;
            if (change_ready) begin
               credit_d = credit_left;
               if (credit_left == '0) begin
                  state_d = COLLECT;
               end
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   assign dispense     = (state_q == DISPENSE);
   assign change_valid = (state_q == CHANGE);
   assign change_coin  = change_valid ? sel_code : NONE;
   assign coin_reject  = reject_q;
   assign credit       = credit_q;
   assign sales        = sales_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Bench for vending_ctrl: two instances (PRICE=3/SALES_W=8 and
// PRICE=15/SALES_W=2) driven by the same stimulus, each compared every
// cycle against a transaction-level model of the vending rules.
module tb_vending_ctrl;

   logic       clk;
   logic       rst;
   logic [1:0] coin;
   logic       cancel;
   logic       dispense_ack;
   logic       change_ready;

   logic       a_dispense, a_change_valid, a_coin_reject;
   logic [1:0] a_change_coin;
   logic [3:0] a_credit;
   logic [7:0] a_sales;

   logic       b_dispense, b_change_valid, b_coin_reject;
   logic [1:0] b_change_coin;
   logic [3:0] b_credit;
   logic [1:0] b_sales;

   int errors = 0;
   int checks = 0;

   vending_ctrl #(
      .PRICE      (3),
      .CREDIT_W   (4),
      .MAX_CREDIT (15),
      .SALES_W    (8)
   ) ua (
      .clk          (clk),
      .rst          (rst),
      .coin         (coin),
      .cancel       (cancel),
      .dispense_ack (dispense_ack),
      .change_ready (change_ready),
      .dispense     (a_dispense),
      .change_valid (a_change_valid),
      .change_coin  (a_change_coin),
      .coin_reject  (a_coin_reject),
      .credit       (a_credit),
      .sales        (a_sales)
   );

   vending_ctrl #(
      .PRICE      (15),
      .CREDIT_W   (4),
      .MAX_CREDIT (15),
      .SALES_W    (2)
   ) ub (
      .clk          (clk),
      .rst          (rst),
      .coin         (coin),
      .cancel       (cancel),
      .dispense_ack (dispense_ack),
      .change_ready (change_ready),
      .dispense     (b_dispense),
      .change_valid (b_change_valid),
      .change_coin  (b_change_coin),
      .coin_reject  (b_coin_reject),
      .credit       (b_credit),
      .sales        (b_sales)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: phase 0 = taking money, 1 = waiting for product release,
   // 2 = paying coins back.
   int m_phase  [2];
   int m_credit [2];
   int m_sales  [2];
   int m_rej    [2];
   int p_price  [2] = '{3, 15};
   int p_max    [2] = '{15, 15};
   int p_smod   [2] = '{256, 4};

   function automatic int units_of(input logic [1:0] c);
      int u [4] = '{0, 1, 2, 4};
      return u[c];
   endfunction

   function automatic int payout(input int cr);
      int opts [3] = '{4, 2, 1};
      for (int i = 0; i < 3; i++) begin
         if (opts[i] <= cr) return opts[i];
      end
      return 0;
   endfunction

   function automatic int code_of(input int units);
      if (units == 4) return 3;
      if (units == 2) return 2;
      if (units == 1) return 1;
      return 0;
   endfunction

   task automatic model_step(input int k);
      int v;
      if (rst) begin
         m_phase[k] = 0; m_credit[k] = 0; m_sales[k] = 0; m_rej[k] = 0;
         return;
      end
      v = units_of(coin);
      m_rej[k] = 0;
      if (m_phase[k] == 0) begin
         if (m_credit[k] >= p_price[k]) begin
            m_credit[k] -= p_price[k];
            m_phase[k] = 1;
            m_rej[k] = (v != 0);
         end else if (cancel && m_credit[k] > 0) begin
            m_phase[k] = 2;
            m_rej[k] = (v != 0);
         end else if (v != 0) begin
            if (m_credit[k] + v <= p_max[k]) m_credit[k] += v;
            else m_rej[k] = 1;
         end
      end else if (m_phase[k] == 1) begin
         m_rej[k] = (v != 0);
         if (dispense_ack) begin
            m_sales[k] = (m_sales[k] + 1) % p_smod[k];
            m_phase[k] = (m_credit[k] > 0) ? 2 : 0;
         end
      end else begin
         m_rej[k] = (v != 0);
         if (change_ready) begin
            m_credit[k] -= payout(m_credit[k]);
            if (m_credit[k] == 0) m_phase[k] = 0;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic check_all();
      check("A.credit",   32'(a_credit),       m_credit[0]);
      check("A.sales",    32'(a_sales),        m_sales[0]);
      check("A.reject",   32'(a_coin_reject),  m_rej[0]);
      check("A.dispense", 32'(a_dispense),     32'(m_phase[0] == 1));
      check("A.cvalid",   32'(a_change_valid), 32'(m_phase[0] == 2));
      check("A.ccoin",    32'(a_change_coin),  (m_phase[0] == 2) ? code_of(payout(m_credit[0])) : 0);
      check("B.credit",   32'(b_credit),       m_credit[1]);
      check("B.sales",    32'(b_sales),        m_sales[1]);
      check("B.reject",   32'(b_coin_reject),  m_rej[1]);
      check("B.dispense", 32'(b_dispense),     32'(m_phase[1] == 1));
      check("B.cvalid",   32'(b_change_valid), 32'(m_phase[1] == 2));
      check("B.ccoin",    32'(b_change_coin),  (m_phase[1] == 2) ? code_of(payout(m_credit[1])) : 0);
   endtask

   task automatic cycle(input logic [1:0] c, input logic can, input logic ack,
                        input logic rdy, input logic r);
      coin = c; cancel = can; dispense_ack = ack; change_ready = rdy; rst = r;
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      coin = 2'b00; cancel = 1'b0; dispense_ack = 1'b0; change_ready = 1'b0; rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         m_phase[k] = 0; m_credit[k] = 0; m_sales[k] = 0; m_rej[k] = 0;
      end

      // Reset state
      do_reset();
      do_reset();
      check("rst.credit", 32'(a_credit), 0);
      check("rst.dispense", 32'(a_dispense), 0);
      check("rst.ccoin", 32'(a_change_coin), 0);

      // Three 50 ct coins, exact price
      cycle(2'b01, 0, 0, 0, 0);
      cycle(2'b01, 0, 0, 0, 0);
      cycle(2'b01, 0, 0, 0, 0);
      check("exact.credit", 32'(a_credit), 3);
      cycle(2'b00, 0, 0, 0, 0);
      check("exact.dispense", 32'(a_dispense), 1);
      check("exact.credit0", 32'(a_credit), 0);
      cycle(2'b00, 0, 1, 0, 0);
      check("exact.sales", 32'(a_sales), 1);
      check("exact.nochange", 32'(a_change_valid), 0);

      // Overpay: 1 EUR + 2 EUR, change 1 EUR then 50 ct
      do_reset();
      cycle(2'b10, 0, 0, 1, 0);
      cycle(2'b11, 0, 0, 1, 0);
      check("over.credit6", 32'(a_credit), 6);
      cycle(2'b00, 0, 0, 1, 0);
      check("over.credit3", 32'(a_credit), 3);
      cycle(2'b00, 0, 1, 1, 0);
      check("over.coin10", 32'(a_change_coin), 2);
      cycle(2'b00, 0, 0, 1, 0);
      check("over.coin01", 32'(a_change_coin), 1);
      check("over.credit1", 32'(a_credit), 1);
      cycle(2'b00, 0, 0, 1, 0);
      check("over.done", 32'(a_change_valid), 0);

      // Cancel with coin in the same cycle, hopper stalls
      do_reset();
      cycle(2'b10, 0, 0, 0, 0);
      cycle(2'b11, 1, 0, 0, 0);
      check("cancel.reject", 32'(a_coin_reject), 1);
      for (int i = 0; i < 3; i++) begin
         cycle(2'b00, 0, 0, 0, 0);
         check("cancel.stable", 32'(a_change_coin), 2);
         check("cancel.credit", 32'(a_credit), 2);
      end
      cycle(2'b00, 0, 0, 1, 0);
      check("cancel.done", 32'(a_credit), 0);

      // Coins and cancel while busy
      do_reset();
      cycle(2'b10, 0, 0, 0, 0);
      cycle(2'b10, 0, 0, 0, 0);
      cycle(2'b01, 1, 0, 0, 0);
      cycle(2'b01, 1, 0, 0, 0);
      check("busy.disp_reject", 32'(a_coin_reject), 1);
      check("busy.disp_hold", 32'(a_dispense), 1);
      cycle(2'b00, 0, 1, 0, 0);
      cycle(2'b01, 0, 0, 0, 0);
      check("busy.chg_reject", 32'(a_coin_reject), 1);
      check("busy.chg_credit", 32'(a_credit), 1);
      cycle(2'b00, 0, 0, 1, 0);

      // Reset in the middle of paying change
      do_reset();
      cycle(2'b10, 0, 0, 0, 0);
      cycle(2'b11, 0, 0, 0, 0);
      cycle(2'b00, 0, 0, 0, 0);
      cycle(2'b00, 0, 1, 0, 0);
      check("abort.credit3", 32'(a_credit), 3);
      do_reset();
      check("abort.credit", 32'(a_credit), 0);
      check("abort.cvalid", 32'(a_change_valid), 0);

      // Ceiling on the PRICE=15 instance
      do_reset();
      cycle(2'b11, 0, 0, 0, 0);
      cycle(2'b11, 0, 0, 0, 0);
      cycle(2'b11, 0, 0, 0, 0);
      cycle(2'b01, 0, 0, 0, 0);
      cycle(2'b11, 0, 0, 0, 0);
      check("max.reject", 32'(b_coin_reject), 1);
      check("max.credit13", 32'(b_credit), 13);
      cycle(2'b10, 0, 0, 0, 0);
      check("max.credit15", 32'(b_credit), 15);
      cycle(2'b00, 0, 0, 0, 0);
      check("max.dispense", 32'(b_dispense), 1);

      // Five sales on a 2-bit sales counter
      do_reset();
      for (int s = 0; s < 5; s++) begin
         cycle(2'b11, 0, 1, 1, 0);
         cycle(2'b11, 0, 1, 1, 0);
         cycle(2'b11, 0, 1, 1, 0);
         cycle(2'b10, 0, 1, 1, 0);
         cycle(2'b01, 0, 1, 1, 0);
         cycle(2'b00, 0, 1, 1, 0);
         cycle(2'b00, 0, 1, 1, 0);
      end
      check("wrap.sales", 32'(b_sales), 1);

      // Random traffic
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         logic [1:0] c;
         c = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         cycle(c,
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 1) == 0),
               ($urandom_range(0, 199) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vending_ctrl.md
Name: vending_ctrl

Overview:
- Parametrised vending controller, successor of the fixed-price 4-state coin FSM.
- Accepts 50 ct / 1 EUR / 2 EUR coins and compares accumulated credit against a parametrised price.
- Raises a held dispense request with acknowledge, returns change and refunds one coin at a time over a hopper handshake, and counts sales.
- Sits between the coin validator and the dispense/hopper actuators.

Parameters:
- PRICE, 3, product price in 50 ct units (3 = 1.50 EUR); legal range 1..MAX_CREDIT.
- CREDIT_W, 4, credit register width in 50 ct units.
- MAX_CREDIT, 15, highest credit accepted; must be <= 2**CREDIT_W-1.
- SALES_W, 8, width of the sales counter.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- rst, input, 1, synchronous reset, active-high.
- coin, input, 2, coin code: 00 none, 01 50 ct (1 unit), 10 1 EUR (2 units), 11 2 EUR (4 units); single-cycle per coin.
- cancel, input, 1, refund request.
- dispense_ack, input, 1, product released.
- change_ready, input, 1, hopper accepts the presented coin.
- dispense, output, 1, dispense request; held until acknowledged.
- change_valid, output, 1, a coin is presented to the hopper.
- change_coin, output, 2, code of the presented coin; same encoding as coin.
- coin_reject, output, 1, one-cycle pulse: the previous cycle's coin was not credited.
- credit, output, CREDIT_W, current credit in units.
- sales, output, SALES_W, completed sales; wraps modulo 2**SALES_W.

Behaviour:
- Reset (synchronous, rst=1 at an edge): state COLLECT, credit=0, sales=0, coin_reject=0. Resulting outputs: dispense=0, change_valid=0, change_coin=00. Reset mid-dispense or mid-change aborts the transaction and discards credit.
- Outputs dispense, change_valid, change_coin and credit decode registers only; there is no input-to-output combinational path. coin_reject is a registered pulse.
- States: COLLECT, DISPENSE, CHANGE. Binary encoded.
- COLLECT, evaluated in priority order each edge:
  - credit >= PRICE: go to DISPENSE; credit <= credit-PRICE. A coin arriving this cycle is rejected; cancel is ignored (purchase committed).
  - else cancel=1 and credit>0: go to CHANGE (refund). A coin in the same cycle is rejected.
  - else cancel=1 and credit=0: ignored. A coin in the same cycle is processed as below.
  - else coin!=00: if credit+value <= MAX_CREDIT, credit <= credit+value, visible the next cycle. Otherwise the coin is rejected and credit is unchanged. Compute the sum at CREDIT_W+1 bits; no wrap.
- Latency: a coin is accepted at edge N. credit>=PRICE is visible after N. The DISPENSE state, with dispense=1, is entered at edge N+1.
- DISPENSE: dispense=1. Every incoming coin is rejected; cancel is ignored. On dispense_ack=1: sales <= sales+1; next state is CHANGE if credit>0, else COLLECT.
- CHANGE: change_valid=1. change_coin is the largest coin <= credit: 11 if credit>=4, 10 if >=2, else 01.
  - On change_ready=1: credit <= credit-value. If the result is 0, go to COLLECT; otherwise stay in CHANGE.
  - change_coin must remain stable while change_ready=0.
  - Incoming coins are rejected; cancel is ignored.
- coin_reject: set to 1 at the edge after any cycle where coin!=00 was not credited; 0 otherwise.
- Overpay with a single coin is legal. Example: PRICE=3 with credit 2 plus a 2 EUR coin gives credit 6, then credit 3 after DISPENSE, then change 10 followed by 01.
- Elaboration check: assert PRICE>=1 and PRICE<=MAX_CREDIT<=2**CREDIT_W-1.

Decomposition:
- Package vending_pkg:
  - coin code enum (NONE, C50, C100, C200).
  - state enum (COLLECT, DISPENSE, CHANGE).
  - function coin_value(code) returning units.
- Sub-module vending_change_sel: combinational; maps credit to the largest returnable coin code and its value. It is reused by the refund and change paths.

Test Plan:
- PRICE=3, coins 01,01,01 on consecutive cycles: credit 1,2,3. dispense=1 one cycle later and credit=0. ack: sales=1, state COLLECT, no change_valid.
- PRICE=3, coin 10 then 11: credit 6. Then DISPENSE with credit 3. After ack, with change_ready held 1: change_coin 10 then 01, credit 1 then 0, back to COLLECT.
- credit=2, cancel=1 together with coin=11: coin_reject pulses next cycle. Refund change_coin=10. With change_ready=0 for 3 cycles, change_coin stays 10 and credit stays 2; the transfer completes on ready.
- MAX_CREDIT=15, PRICE=15, credit=13, coin 11: rejected with credit still 13. Coin 10: credit 15, then DISPENSE.
- Coin 01 during DISPENSE and during CHANGE: coin_reject=1 each time, credit unchanged. Cancel during DISPENSE: no effect.
- rst asserted while in CHANGE with credit 3: next cycle state COLLECT, credit 0, all outputs 0, sales unchanged by the aborted sale. Separately, SALES_W=2 with 5 sales: sales=1.
